// File: rtl/axis_buf_pkg.sv
// Shared types and helpers for the AXI-Stream elastic buffer.
package axis_buf_pkg;

  typedef enum logic {
    MODE_FALLTHROUGH,
    MODE_REGISTERED
  } axis_buf_mode_e;

  function automatic int ptr_w(input int depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/axis_buf_mem.sv
// Beat storage: register array with one synchronous write port and one
// asynchronous read port; contents are never reset.
module axis_buf_mem
  import axis_buf_pkg::*;
#(
  parameter int WIDTH = 11,
  parameter int DEPTH = 2,
  localparam int AW   = ptr_w(DEPTH)
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/axis_elastic_buffer.sv
// AXI-Stream elastic buffer: DEPTH-entry circular buffer with a registered
// ready_o, optional zero-latency fall-through when empty.
module axis_elastic_buffer
  import axis_buf_pkg::*;
#(
  parameter int             DATA_WIDTH = 10,
  parameter int             DEPTH      = 2,
  parameter axis_buf_mode_e MODE       = MODE_FALLTHROUGH
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic [DATA_WIDTH-1:0]        data_i,
  input  logic                         last_i,
  input  logic                         valid_i,
  output logic                         ready_o,
  output logic [DATA_WIDTH-1:0]        data_o,
  output logic                         last_o,
  output logic                         valid_o,
  input  logic                         ready_i,
  output logic [$clog2(DEPTH):0]       count_o
);

  localparam int            PW          = ptr_w(DEPTH);
  localparam int            CW          = PW + 1;
  localparam logic [CW-1:0] DEPTH_C     = CW'(DEPTH);
  localparam bit            FALLTHROUGH = (MODE == MODE_FALLTHROUGH);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("axis_elastic_buffer: DEPTH must be a power of 2 and at least 2");
  end

  logic [PW-1:0]       wptr_q, wptr_d;
  logic [PW-1:0]       rptr_q, rptr_d;
  logic [CW-1:0]       count_q, count_d;
  logic                ready_q, ready_d;
  logic                active_q, active_d;

  logic                empty;
  logic                push;
  logic                pop;
  logic                bypass;
  logic                mem_we;
  logic                mem_re;
  logic                out_valid;
  logic [DATA_WIDTH:0] out_beat;
  logic [DATA_WIDTH:0] mem_rdata;

  axis_buf_mem #(
    .WIDTH (DATA_WIDTH + 1),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk_i   (clk_i),
    .we_i    (mem_we),
    .waddr_i (wptr_q),
    .wdata_i ({last_i, data_i}),
    .raddr_i (rptr_q),
    .rdata_o (mem_rdata)
  );

  // active_q keeps valid_o low from reset until the first edge, so an
  // upstream valid_i held during reset cannot leak through the bypass.
  always_comb begin
    empty = (count_q == '0);
    if (FALLTHROUGH && empty) begin
      out_valid = active_q & valid_i;
      out_beat  = {last_i, data_i};
    end else begin
      out_valid = active_q & !empty;
      out_beat  = mem_rdata;
    end

    push   = valid_i & ready_q;
    pop    = out_valid & ready_i;
    bypass = FALLTHROUGH && empty && push && pop;
    mem_we = push & !bypass;
    mem_re = pop & !bypass;

    wptr_d = wptr_q + PW'(mem_we);
    rptr_d = rptr_q + PW'(mem_re);

    count_d = count_q;
    case ({mem_we, mem_re})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    ready_d  = (count_d < DEPTH_C);
    active_d = 1'b1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wptr_q   <= '0;
      rptr_q   <= '0;
      count_q  <= '0;
      ready_q  <= 1'b0;
      active_q <= 1'b0;
    end else begin
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      count_q  <= count_d;
      ready_q  <= ready_d;
      active_q <= active_d;
    end
  end

  assign ready_o = ready_q;
  assign valid_o = out_valid;
  assign data_o  = out_valid ? out_beat[DATA_WIDTH-1:0] : '0;
  assign last_o  = out_valid ? out_beat[DATA_WIDTH] : 1'b0;
  assign count_o = count_q;

endmodule

// File: tb/tb_axis_elastic_buffer.sv
// Scoreboard bench: instance 0 is fall-through, instance 1 is registered,
// both DEPTH=4; a FIFO-queue reference model checks every output beat.
module tb_axis_elastic_buffer;
  import axis_buf_pkg::*;

  localparam int DW = 10;
  localparam int D  = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [1:0][DW-1:0] data_i = '0;
  logic [1:0]       last_i  = '0;
  logic [1:0]       valid_i = '0;
  logic [1:0]       ready_i = '0;
  logic [1:0][DW-1:0] data_o;
  logic [1:0]       last_o;
  logic [1:0]       valid_o;
  logic [1:0]       ready_o;
  logic [1:0][2:0]  count_o;

  int n_checks = 0;
  int n_fail   = 0;
  int acc_cnt [2];

  always #5 clk = ~clk;

  axis_elastic_buffer #(.DATA_WIDTH(DW), .DEPTH(D), .MODE(MODE_FALLTHROUGH)) u_ft (
    .clk_i(clk), .rst_i(rst), .data_i(data_i[0]), .last_i(last_i[0]), .valid_i(valid_i[0]),
    .ready_o(ready_o[0]), .data_o(data_o[0]), .last_o(last_o[0]), .valid_o(valid_o[0]),
    .ready_i(ready_i[0]), .count_o(count_o[0])
  );

  axis_elastic_buffer #(.DATA_WIDTH(DW), .DEPTH(D), .MODE(MODE_REGISTERED)) u_rg (
    .clk_i(clk), .rst_i(rst), .data_i(data_i[1]), .last_i(last_i[1]), .valid_i(valid_i[1]),
    .ready_o(ready_o[1]), .data_o(data_o[1]), .last_o(last_o[1]), .valid_o(valid_o[1]),
    .ready_i(ready_i[1]), .count_o(count_o[1])
  );

  task automatic chk(input string name, input int inst, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s inst%0d @%0t: got %0h expected %0h", name, inst, $time, act, exp);
    end
  endtask

  // Reference model: the buffer is a FIFO of accepted beats; the number held
  // equals the queue length, and valid_o is set by what the model holds.
  for (genvar gi = 0; gi < 2; gi++) begin : g_mon
    logic [DW:0] q [$];
    int          n;
    logic        exp_v;
    always @(negedge clk) begin
      if (rst) begin
        q.delete();
        chk("rst_valid", gi, valid_o[gi], 0);
        chk("rst_ready", gi, ready_o[gi], 0);
        chk("rst_data",  gi, {last_o[gi], data_o[gi]}, 0);
        chk("rst_count", gi, count_o[gi], 0);
      end else begin
        n     = q.size();
        exp_v = (gi == 0) ? (n != 0 || valid_i[gi]) : (n != 0);
        chk("count", gi, count_o[gi], n);
        chk("ready", gi, ready_o[gi], n < D);
        chk("valid", gi, valid_o[gi], exp_v);
        if (valid_i[gi] && ready_o[gi]) begin
          q.push_back({last_i[gi], data_i[gi]});
          acc_cnt[gi]++;
        end
        if (valid_o[gi]) begin
          if (q.size() == 0) begin
            chk("spurious_beat", gi, {last_o[gi], data_o[gi]}, 32'hFFFF_FFFF);
          end else begin
            chk("beat", gi, {last_o[gi], data_o[gi]}, q[0]);
            if (ready_i[gi]) void'(q.pop_front());
          end
        end
      end
    end
  end

  task automatic cyc(input logic [1:0] v, input logic [1:0] r, input logic [DW-1:0] d, input logic l);
    @(posedge clk);
    #1;
    valid_i   = v;
    ready_i   = r;
    data_i[0] = d;
    data_i[1] = d;
    last_i    = {l, l};
  endtask

  initial begin
    acc_cnt[0] = 0;
    acc_cnt[1] = 0;

    // Reset held for 3 cycles with upstream valid asserted.
    valid_i = 2'b11; ready_i = 2'b11; data_i[0] = 10'h2AA; data_i[1] = 10'h2AA;
    #1;
    for (int i = 0; i < 2; i++) chk("rst_valid_t0", i, valid_o[i], 0);
    repeat (3) @(negedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk("ready_after_rst", i, ready_o[i], 1);
      chk("count_after_rst", i, count_o[i], 0);
    end

    // Fall-through pass: zero latency, nothing stored.
    for (int i = 1; i <= 16; i++) begin
      cyc(2'b11, 2'b11, DW'(i), 1'b0);
      @(negedge clk);
      chk("ft_same_cycle", 0, data_o[0], i);
      chk("ft_count0", 0, count_o[0], 0);
    end
    repeat (3) cyc(2'b00, 2'b11, '0, 1'b0);

    // Fill to full, hold a fifth beat, then pop once while full.
    for (int i = 1; i <= 4; i++) cyc(2'b11, 2'b00, 10'h0A0 + DW'(i), 1'b0);
    repeat (3) cyc(2'b11, 2'b00, 10'h0A5, 1'b1);
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk("full_count", i, count_o[i], D);
      chk("full_ready", i, ready_o[i], 0);
    end
    cyc(2'b11, 2'b11, 10'h0A5, 1'b1);
    @(negedge clk);
    for (int i = 0; i < 2; i++) chk("ready_before_pop_edge", i, ready_o[i], 0);
    cyc(2'b11, 2'b00, 10'h0A5, 1'b1);
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk("pop_full_count", i, count_o[i], D - 1);
      chk("pop_full_ready", i, ready_o[i], 1);
    end
    repeat (8) cyc(2'b00, 2'b11, '0, 1'b0);

    // Registered mode: exactly one cycle of latency.
    cyc(2'b11, 2'b11, 10'h155, 1'b1);
    @(negedge clk);
    chk("reg_not_yet", 1, valid_o[1], 0);
    cyc(2'b00, 2'b11, '0, 1'b0);
    @(negedge clk);
    chk("reg_valid", 1, valid_o[1], 1);
    chk("reg_data", 1, data_o[1], 10'h155);
    chk("reg_last", 1, last_o[1], 1);
    repeat (3) cyc(2'b00, 2'b11, '0, 1'b0);

    // Random traffic, 50% valid / 50% ready, at least 1000 beats each.
    acc_cnt[0] = 0;
    acc_cnt[1] = 0;
    for (int c = 0; c < 8000 && (acc_cnt[0] < 1000 || acc_cnt[1] < 1000); c++) begin
      @(posedge clk);
      #1;
      for (int i = 0; i < 2; i++) begin
        valid_i[i] = 1'($urandom_range(0, 1));
        ready_i[i] = 1'($urandom_range(0, 1));
        data_i[i]  = DW'($urandom);
        last_i[i]  = 1'($urandom_range(0, 1));
      end
    end
    chk("rand_budget", 0, (acc_cnt[0] >= 1000 && acc_cnt[1] >= 1000), 1);
    repeat (8) cyc(2'b00, 2'b11, '0, 1'b0);
    @(negedge clk);
    for (int i = 0; i < 2; i++) chk("rand_drained", i, count_o[i], 0);

    // Reset with 3 beats stored: they must never appear afterwards.
    for (int i = 1; i <= 3; i++) cyc(2'b11, 2'b00, 10'h3F0 + DW'(i), 1'b0);
    cyc(2'b00, 2'b00, '0, 1'b0);
    @(negedge clk);
    for (int i = 0; i < 2; i++) chk("pre_rst_count", i, count_o[i], 3);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    for (int i = 0; i < 2; i++) begin
      chk("async_rst_valid", i, valid_o[i], 0);
      chk("async_rst_count", i, count_o[i], 0);
    end
    repeat (2) @(negedge clk);
    #1 rst = 1'b0;
    repeat (5) cyc(2'b00, 2'b11, '0, 1'b0);
    for (int i = 1; i <= 4; i++) cyc(2'b11, 2'b11, 10'h050 + DW'(i), 1'b0);
    repeat (6) cyc(2'b00, 2'b11, '0, 1'b0);
    @(negedge clk);
    for (int i = 0; i < 2; i++) chk("post_rst_drained", i, count_o[i], 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
